// File: rtl/spinner_pkg.sv
// Shared types and tables for the spinner/dial emulator.
// Latency: n/a (package). Backpressure: n/a.
package spinner_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} dial_state_t;

  localparam logic [1:0] DIAL_IDLE = 2'b11;
  localparam logic [1:0] PHASE_RST = 2'd2;
  localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic logic [1:0] phase_next(input logic [1:0] idx, input logic up);
    return up ? idx + 2'd1 : idx - 2'd1;
  endfunction

endpackage

// File: rtl/spinner_chan.sv
// One dial channel: button decode, accelerating step timer, gray phase / pulse output, position.
// Latency: first step one cycle after a request. Backpressure: none, outputs are free-running.
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int BASE_DIV  = 48000,
  parameter int MIN_DIV   = 6000,
  parameter int ACCEL_DEC = 2625,
  parameter int PULSE_W   = 64
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       en,
  input  logic       mode,
  input  logic       inv,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [1:0] dial_out,
  output logic       step_strobe,
  output logic [7:0] pos
);

  if (PULSE_W >= MIN_DIV || PULSE_W < 1) begin : g_bad_pulse_w
    $error("spinner_chan: PULSE_W must be in 1..MIN_DIV-1");
  end

  localparam logic [DIV_W-1:0] BASE  = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] MIN   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W:0]   ACC_X = (DIV_W+1)'(ACCEL_DEC);
  localparam logic [DIV_W-1:0] PW_M1 = DIV_W'(PULSE_W - 1);

  dial_state_t      state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] ptmr;
  logic             pulse_act;
  logic             dir_up;
  logic [1:0]       phase;

  logic             inc_e, dec_e, req, up;
  logic             fresh, step;
  logic [DIV_W-1:0] cur_div, nxt_div;
  logic [DIV_W:0]   diff;

  assign inc_e = inv ? btn_dec : btn_inc;
  assign dec_e = inv ? btn_inc : btn_dec;
  assign req   = inc_e ^ dec_e;
  assign up    = inc_e;

  // A reversal restarts acceleration exactly like a fresh press.
  always_comb begin
    fresh = 1'b0;
    step  = 1'b0;
    if (state == IDLE) begin
      fresh = req;
      step  = req;
    end else if (req) begin
      if (up != dir_up) begin
        fresh = 1'b1;
        step  = 1'b1;
      end else begin
        step = (cnt == '0);
      end
    end
    cur_div = fresh ? BASE : div;
    diff    = {1'b0, cur_div} - ACC_X;
    nxt_div = (diff[DIV_W] || (diff[DIV_W-1:0] < MIN)) ? MIN : diff[DIV_W-1:0];
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n || !en) begin
      state       <= IDLE;
      div         <= BASE;
      cnt         <= '0;
      ptmr        <= '0;
      pulse_act   <= 1'b0;
      dir_up      <= 1'b0;
      phase       <= PHASE_RST;
      dial_out    <= DIAL_IDLE;
      step_strobe <= 1'b0;
      if (!reset_n) pos <= '0;
    end else begin
      step_strobe <= step;
      if (pulse_act) begin
        if (ptmr == '0) begin
          pulse_act <= 1'b0;
          dial_out  <= DIAL_IDLE;
        end else begin
          ptmr <= ptmr - 1'b1;
        end
      end
      if (step) begin
        state  <= RUN;
        dir_up <= up;
        cnt    <= cur_div - 1'b1;
        div    <= nxt_div;
        pos    <= up ? pos + 8'd1 : pos - 8'd1;
        if (mode) begin
          // Parking the phase at 11 lets a later switch to quadrature continue glitch-free.
          dial_out  <= up ? 2'b10 : 2'b01;
          pulse_act <= 1'b1;
          ptmr      <= PW_M1;
          phase     <= PHASE_RST;
        end else begin
          dial_out  <= GRAY_SEQ[phase_next(phase, up)];
          phase     <= phase_next(phase, up);
          pulse_act <= 1'b0;
        end
      end else if (state == RUN) begin
        if (!req) begin
          state <= IDLE;
          div   <= BASE;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spinner_dial_emu.sv
// N-channel spinner/dial emulator: joystick buttons in, active-low quadrature/pulse dial out.
// Latency: one cycle from request to first step. Backpressure: none.
module spinner_dial_emu
  import spinner_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int DIV_W     = 16,
  parameter int BASE_DIV  = 48000,
  parameter int MIN_DIV   = 6000,
  parameter int ACCEL_DEC = 2625,
  parameter int PULSE_W   = 64
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [CHANNELS-1:0]   ch_en,
  input  logic [CHANNELS-1:0]   ch_mode,
  input  logic [CHANNELS-1:0]   ch_inv,
  input  logic [CHANNELS-1:0]   btn_inc,
  input  logic [CHANNELS-1:0]   btn_dec,
  output logic [2*CHANNELS-1:0] dial_out,
  output logic [CHANNELS-1:0]   step_strobe,
  output logic [8*CHANNELS-1:0] pos
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    spinner_chan #(
      .DIV_W    (DIV_W),
      .BASE_DIV (BASE_DIV),
      .MIN_DIV  (MIN_DIV),
      .ACCEL_DEC(ACCEL_DEC),
      .PULSE_W  (PULSE_W)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .en         (ch_en[c]),
      .mode       (ch_mode[c]),
      .inv        (ch_inv[c]),
      .btn_inc    (btn_inc[c]),
      .btn_dec    (btn_dec[c]),
      .dial_out   (dial_out[2*c +: 2]),
      .step_strobe(step_strobe[c]),
      .pos        (pos[8*c +: 8])
    );
  end

endmodule

// File: tb/tb_spinner_dial_emu.sv
// Scoreboard bench for spinner_dial_emu with shortened step intervals.
module tb_spinner_dial_emu;

  typedef struct {
    int         cyc;
    logic [1:0] dial;
    logic [7:0] pos;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  ch_en, ch_mode, ch_inv, btn_inc, btn_dec;
  logic [3:0]  dial_out;
  logic [1:0]  step_strobe;
  logic [15:0] pos;

  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;
  int   t0;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] gray_tb [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  spinner_dial_emu #(
    .CHANNELS(2), .DIV_W(16), .BASE_DIV(10), .MIN_DIV(4), .ACCEL_DEC(3), .PULSE_W(2)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ch_en      (ch_en),
    .ch_mode    (ch_mode),
    .ch_inv     (ch_inv),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .dial_out   (dial_out),
    .step_strobe(step_strobe),
    .pos        (pos)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int t, input logic [1:0] d, input logic [7:0] p);
    exp_t e;
    e.cyc  = t;
    e.dial = d;
    e.pos  = p;
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon_ch(input int c);
    exp_t e;
    bit   empty;
    empty = (c == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      n_run++;
      n_fail++;
      $display("FAIL unexpected_strobe ch%0d at cyc %0d: got strobe expected none", c, cyc);
    end else begin
      if (c == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("strobe_cyc_ch%0d", c), cyc, e.cyc);
      chk($sformatf("strobe_dial_ch%0d", c), {30'd0, dial_out[2*c +: 2]}, {30'd0, e.dial});
      chk($sformatf("strobe_pos_ch%0d", c), {24'd0, pos[8*c +: 8]}, {24'd0, e.pos});
    end
  endtask

  always @(negedge clk_sys) begin
    if (step_strobe[0] === 1'b1) mon_ch(0);
    if (step_strobe[1] === 1'b1) mon_ch(1);
  end

  task automatic nb(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    nb(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    ch_en   = 2'b11;
    ch_mode = 2'b10;
    ch_inv  = 2'b10;
    btn_inc = 2'b11;
    btn_dec = 2'b00;

    // Reset with buttons held.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      chk("rst_strobe", {30'd0, step_strobe}, 32'd0);
    end
    chk("rst_dial", {28'd0, dial_out}, 32'hF);
    chk("rst_pos", {16'd0, pos}, 32'd0);
    btn_inc = 2'b00;
    reset_n = 1'b1;

    // Quadrature with acceleration on ch0.
    nb(1);
    t0 = cyc;
    push(0, t0 + 1,  2'b10, 8'd1);
    push(0, t0 + 11, 2'b00, 8'd2);
    push(0, t0 + 18, 2'b01, 8'd3);
    push(0, t0 + 22, 2'b11, 8'd4);
    push(0, t0 + 26, 2'b10, 8'd5);
    btn_inc[0] = 1'b1;
    wait_cyc(t0 + 27);
    btn_inc[0] = 1'b0;
    nb(10);
    chk("quad_pos", {24'd0, pos[7:0]}, 32'd5);
    chk("quad_dial", {30'd0, dial_out[1:0]}, 32'h2);

    // Reversal then release.
    do_reset();
    t0 = cyc;
    push(0, t0 + 1,  2'b10, 8'd1);
    push(0, t0 + 11, 2'b00, 8'd2);
    push(0, t0 + 18, 2'b01, 8'd3);
    push(0, t0 + 20, 2'b00, 8'd2);
    btn_inc[0] = 1'b1;
    wait_cyc(t0 + 19);
    btn_inc[0] = 1'b0;
    btn_dec[0] = 1'b1;
    wait_cyc(t0 + 21);
    btn_dec[0] = 1'b0;
    nb(50);
    chk("rev_hold_dial", {30'd0, dial_out[1:0]}, 32'h0);
    chk("rev_hold_pos", {24'd0, pos[7:0]}, 32'd2);
    chk("rev_q0_empty", q0.size(), 32'd0);

    // Pulse mode with inversion on ch1.
    t0 = cyc;
    push(1, t0 + 1, 2'b01, 8'd255);
    btn_inc[1] = 1'b1;
    nb(1);
    btn_inc[1] = 1'b0;
    chk("pulse_c1", {30'd0, dial_out[3:2]}, 32'h1);
    nb(1);
    chk("pulse_c2", {30'd0, dial_out[3:2]}, 32'h1);
    nb(1);
    chk("pulse_end", {30'd0, dial_out[3:2]}, 32'h3);
    chk("pulse_ch0_dial", {30'd0, dial_out[1:0]}, 32'h0);
    chk("pulse_ch0_pos", {24'd0, pos[7:0]}, 32'd2);

    // Both buttons together.
    btn_inc[0] = 1'b1;
    btn_dec[0] = 1'b1;
    nb(20);
    btn_inc[0] = 1'b0;
    btn_dec[0] = 1'b0;
    nb(2);
    chk("both_pos", {24'd0, pos[7:0]}, 32'd2);
    chk("both_dial", {30'd0, dial_out[1:0]}, 32'h0);

    // Disable mid-pulse, then re-enable.
    nb(5);
    t0 = cyc;
    push(1, t0 + 1, 2'b01, 8'd254);
    btn_inc[1] = 1'b1;
    nb(1);
    ch_en[1]   = 1'b0;
    btn_inc[1] = 1'b0;
    nb(1);
    chk("dis_dial", {30'd0, dial_out[3:2]}, 32'h3);
    chk("dis_pos", {24'd0, pos[15:8]}, 32'd254);
    ch_en[1] = 1'b1;
    nb(3);
    chk("reen_dial", {30'd0, dial_out[3:2]}, 32'h3);

    // 256 steps wrap ch0 while ch1 sits idle.
    do_reset();
    t0 = cyc;
    push(1, t0 + 1, 2'b01, 8'd255);
    btn_inc[1] = 1'b1;
    nb(1);
    btn_inc[1] = 1'b0;
    nb(5);
    t0 = cyc;
    for (int k = 1; k <= 256; k++) begin
      push(0, t0 + ((k == 1) ? 1 : (k == 2) ? 11 : 18 + 4 * (k - 3)),
           gray_tb[(2 + k) % 4], 8'(k));
    end
    btn_inc[0] = 1'b1;
    wait_cyc(t0 + 1031);
    btn_inc[0] = 1'b0;
    nb(10);
    chk("wrap_pos", {24'd0, pos[7:0]}, 32'd0);
    chk("wrap_ch1_pos", {24'd0, pos[15:8]}, 32'd255);
    chk("wrap_ch1_dial", {30'd0, dial_out[3:2]}, 32'h3);
    chk("end_q0_empty", q0.size(), 32'd0);
    chk("end_q1_empty", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
